syscall_server: RTL
===================

# syscall_server

Service end of the syscall strobes. Accepts one of the five decoded syscall strobes (get_int, print_acc, print_regs, print_string, print_stack), stalls the CPU via `busy`, performs the request against data memory and the accumulator, and streams ASCII bytes to the console over a valid/ready port. It sits between the syscall decoder, the CPU datapath (acc, sp, register snapshot), the data-memory read port and the console sink.

## Interface
- NREGS, 4: registers in `regs_flat` snapshot.
- MAX_STR, 32: maximum characters emitted by print_string before forced termination.
- INT_BASE, 8'h80: reset value of the get_int read pointer.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- get_int, print_acc, print_regs, print_string, print_stack  in  1 each  syscall strobes from the decoder, level while syscall instruction is held.
- acc  in  8  accumulator value.
- sp  in  8  stack pointer (next free slot; stack grows down from 0xFF).
- regs_flat  in  8*NREGS  register snapshot; reg i = bits [8i+7:8i].
- busy  out  1  CPU stall request.
- done  out  1  one-cycle completion pulse.
- acc_we  out  1  accumulator write strobe (get_int).
- acc_wdata  out  8  accumulator write data.
- mem_rd  out  1  data-memory read request.
- mem_addr  out  8  read address.
- mem_rdata  in  8  read data, valid the cycle after `mem_rd`.
- out_valid  out  1  console byte valid.
- out_ready  in  1  console accepts byte.
- out_data  out  8  ASCII byte.

## Operation
- States: IDLE, MEM_REQ, MEM_WAIT, GI_WR, STR_OUT, HEX_HI, HEX_LO, SEP, NL, DONE.
- Strobes sampled only in IDLE; priority if several high: get_int > print_acc > print_regs > print_string > print_stack. acc, sp, regs_flat latched at accept.
- Hex encoding: nibble n<10 -> 0x30+n, else 0x37+n (uppercase). SEP = 0x20, NL = 0x0A.
- get_int: MEM_REQ (mem_rd=1, mem_addr=int_ptr) -> GI_WR (acc_we=1, acc_wdata=mem_rdata; int_ptr+1, wraps 0xFF->0x00) -> DONE.
- print_acc: HEX_HI, HEX_LO of latched acc -> NL -> DONE.
- print_regs: for i = 0..NREGS-1: HEX_HI, HEX_LO, SEP; then NL -> DONE.
- print_string: addr = latched acc. MEM_REQ -> MEM_WAIT (capture byte); byte 0x00 -> NL; else STR_OUT; on transfer addr+1 (wraps), count+1; count==MAX_STR -> NL, else MEM_REQ. Terminator never emitted.
- print_stack: addr from 0xFF down to latched sp+1; per entry MEM_REQ, MEM_WAIT, HEX_HI, HEX_LO, SEP; then NL -> DONE. sp==0xFF (empty): NL only.
- Every output byte state holds out_valid=1 with stable out_data until out_ready; advances only on out_valid&&out_ready.
- DONE: done=1 one cycle, -> IDLE.

## Timing
- Reset values: state IDLE, busy 0 (absent strobes), done 0, acc_we 0, acc_wdata 0, mem_rd 0, mem_addr 0, out_valid 0, out_data 0, int_ptr INT_BASE.
- busy = (state != IDLE) | (IDLE & any strobe), combinational, so stall begins in the strobe cycle T and holds through DONE.
- print_acc, out_ready=1: accept T; bytes T+1, T+2, T+3; done T+4; IDLE T+5.
- get_int: mem_rd T+1, acc_we T+2, done T+3.
- String char: 3 cycles minimum (MEM_REQ, MEM_WAIT, STR_OUT).
- rst mid-operation: immediate return to IDLE, in-flight byte dropped, int_ptr restored to INT_BASE.
- Strobes during non-IDLE states ignored.

## Configuration
- SYSCALL_SERVER_STACK_EN: defined -> print_stack served as above. Undefined -> print_stack accepted, goes straight to DONE (busy T..T+1, done T+1), no memory reads, no bytes; stack address counter not built.

## Structure
- Package `syscall_pkg`: state enum, ASCII constants (NL, SEP, '0' offset 0x30, 'A'-10 offset 0x37), strobe priority encoding.
- One sub-module: `syscall_hex_digit` (4-bit nibble -> 8-bit ASCII), instantiated twice (hi/lo) or muxed once.

## Test plan
- Reset with INT_BASE=0x80, mem[0x80]=0x2A, mem[0x81]=0x07; get_int twice -> acc_we with 0x2A then 0x07, done each time.
- acc=0x3C, print_acc, out_ready=1 -> bytes 0x33, 0x43, 0x0A; done at T+4.
- regs_flat=0x00_FF_10_A5 (NREGS=4), print_regs, out_ready toggling 1/0 -> "A5 10 FF 00 \n", no byte lost or duplicated, out_data stable while stalled.
- acc=0xFE, mem[0xFE..0x01]="Hi!\0" across wrap -> 0x48, 0x69, 0x21, 0x0A; separate string of 40 nonzero bytes -> exactly 32 chars then 0x0A.
- sp=0xFC, mem[0xFF]=0x01, mem[0xFE]=0x02, mem[0xFD]=0x03, print_stack -> "01 02 03 \n"; sp=0xFF -> 0x0A only; macro undefined -> no bytes, done at T+1.
- rst asserted mid print_string -> out_valid, busy, mem_rd 0 immediately; next print_acc runs cleanly.

Source files
------------

// File: rtl/syscall_pkg.sv
// syscall_server shared types: FSM states, request opcodes, ASCII constants
// and the fixed strobe priority.
package syscall_pkg;

  typedef enum logic [3:0] {
    IDLE, MEM_REQ, MEM_WAIT, GI_WR, STR_OUT,
    HEX_HI, HEX_LO, SEP, NL, DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_GI, OP_PACC, OP_PREGS, OP_PSTR, OP_PSTK
  } op_t;

  localparam logic [7:0] ASCII_NL    = 8'h0A;
  localparam logic [7:0] ASCII_SEP   = 8'h20;
  localparam logic [7:0] ASCII_DIG   = 8'h30;
  localparam logic [7:0] ASCII_ALPHA = 8'h37;

  // stb = {print_stack, print_string, print_regs, print_acc, get_int}
  function automatic op_t pick_op(input logic [4:0] stb);
    if (stb[0])      return OP_GI;
    else if (stb[1]) return OP_PACC;
    else if (stb[2]) return OP_PREGS;
    else if (stb[3]) return OP_PSTR;
    else             return OP_PSTK;
  endfunction

endpackage

// File: rtl/syscall_hex_digit.sv
// Nibble to uppercase ASCII hex digit.
import syscall_pkg::*;

module syscall_hex_digit (
  input  logic [3:0] nib,
  output logic [7:0] ascii
);

  assign ascii = (nib < 4'd10) ? ASCII_DIG + {4'h0, nib}
                               : ASCII_ALPHA + {4'h0, nib};

endmodule

// File: rtl/syscall_server.sv
// Syscall service FSM: get_int, print_acc/regs/string/stack to console.
// print_stack traversal is built only with SYSCALL_SERVER_STACK_EN.
import syscall_pkg::*;

module syscall_server #(
  parameter int          NREGS    = 4,
  parameter int          MAX_STR  = 32,
  parameter logic [7:0]  INT_BASE = 8'h80
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               get_int,
  input  logic               print_acc,
  input  logic               print_regs,
  input  logic               print_string,
  input  logic               print_stack,
  input  logic [7:0]         acc,
  input  logic [7:0]         sp,
  input  logic [8*NREGS-1:0] regs_flat,
  output logic               busy,
  output logic               done,
  output logic               acc_we,
  output logic [7:0]         acc_wdata,
  output logic               mem_rd,
  output logic [7:0]         mem_addr,
  input  logic [7:0]         mem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_data
);

  localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int CW = $clog2(MAX_STR + 1);

  state_t             state;
  op_t                op;
  op_t                sel;
  logic [7:0]         int_ptr;
  logic [7:0]         addr;
  logic [7:0]         val;
  logic [8*NREGS-1:0] regs_q;
  logic [RW-1:0]      ridx;
  logic [CW-1:0]      cnt;
  logic [4:0]         stb;
  logic               any_stb;
  logic               xfer;
  logic [3:0]         nib;
  logic [7:0]         hex_asc;

`ifdef SYSCALL_SERVER_STACK_EN
  logic [7:0]         sp_q;
`else
  logic               sp_unused;
  assign sp_unused = ^sp;
`endif

  assign stb     = {print_stack, print_string, print_regs,
                    print_acc, get_int};
  assign any_stb = |stb;
  assign sel     = pick_op(stb);
  assign busy    = (state != IDLE) | any_stb;

  assign done      = (state == DONE);
  assign acc_we    = (state == GI_WR);
  assign acc_wdata = acc_we ? mem_rdata : 8'h00;
  assign mem_rd    = (state == MEM_REQ);
  assign mem_addr  = mem_rd ? addr : 8'h00;
  assign out_valid = (state == STR_OUT) | (state == HEX_HI) |
                     (state == HEX_LO) | (state == SEP) |
                     (state == NL);
  assign xfer      = out_valid & out_ready;

  assign nib = (state == HEX_HI) ? val[7:4] : val[3:0];

  syscall_hex_digit u_hex (
    .nib   (nib),
    .ascii (hex_asc)
  );

  always_comb begin
    out_data = 8'h00;
    unique case (state)
      STR_OUT:        out_data = val;
      HEX_HI, HEX_LO: out_data = hex_asc;
      SEP:            out_data = ASCII_SEP;
      NL:             out_data = ASCII_NL;
      default:        out_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      op      <= OP_GI;
      int_ptr <= INT_BASE;
      addr    <= 8'h00;
      val     <= 8'h00;
      regs_q  <= '0;
      ridx    <= '0;
      cnt     <= '0;
`ifdef SYSCALL_SERVER_STACK_EN
      sp_q    <= 8'h00;
`endif
    end else begin
      unique case (state)
        IDLE: if (any_stb) begin
          op <= sel;
          unique case (sel)
            OP_GI: begin
              addr  <= int_ptr;
              state <= MEM_REQ;
            end
            OP_PACC: begin
              val   <= acc;
              state <= HEX_HI;
            end
            OP_PREGS: begin
              regs_q <= regs_flat;
              val    <= regs_flat[7:0];
              ridx   <= '0;
              state  <= HEX_HI;
            end
            OP_PSTR: begin
              addr  <= acc;
              cnt   <= '0;
              state <= MEM_REQ;
            end
            default: begin
`ifdef SYSCALL_SERVER_STACK_EN
              sp_q  <= sp;
              addr  <= 8'hFF;
              state <= (sp == 8'hFF) ? NL : MEM_REQ;
`else
              state <= DONE;
`endif
            end
          endcase
        end
        MEM_REQ:
          state <= (op == OP_GI) ? GI_WR : MEM_WAIT;
        MEM_WAIT: begin
          val <= mem_rdata;
          if (op == OP_PSTR)
            state <= (mem_rdata == 8'h00) ? NL : STR_OUT;
          else
            state <= HEX_HI;
        end
        GI_WR: begin
          int_ptr <= int_ptr + 8'd1;
          state   <= DONE;
        end
        STR_OUT: if (xfer) begin
          addr  <= addr + 8'd1;
          cnt   <= cnt + 1'b1;
          state <= (cnt == CW'(MAX_STR - 1)) ? NL : MEM_REQ;
        end
        HEX_HI: if (xfer)
          state <= HEX_LO;
        HEX_LO: if (xfer)
          state <= (op == OP_PACC) ? NL : SEP;
        SEP: if (xfer) begin
          if (op == OP_PREGS) begin
            if (ridx == RW'(NREGS - 1)) begin
              state <= NL;
            end else begin
              ridx   <= ridx + 1'b1;
              regs_q <= regs_q >> 8;
              val    <= 8'(regs_q >> 8);
              state  <= HEX_HI;
            end
          end else begin
`ifdef SYSCALL_SERVER_STACK_EN
            if (addr == sp_q + 8'd1) begin
              state <= NL;
            end else begin
              addr  <= addr - 8'd1;
              state <= MEM_REQ;
            end
`else
            state <= NL;
`endif
          end
        end
        NL: if (xfer)
          state <= DONE;
        DONE:
          state <= IDLE;
        default:
          state <= IDLE;
      endcase
    end
  end

endmodule
